// File: rtl/rank_filter_pkg.sv
// Shared constants for the 3x3 rank filter: rank-select mode encoding and pipeline depth.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rank_filter_pkg;

  // Rank selected for a window. Code 3 is reserved and behaves as median.
  typedef enum logic [1:0] {
    MODE_MIN = 2'd0,
    MODE_MED = 2'd1,
    MODE_MAX = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  // Register stages between column accept and out_data, accept edge included.
  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/window3x3_rank_filter_sort3_net.sv
// Purpose: combinational 3-input unsigned sorter producing lo <= md <= hi.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller's registers decide when results are captured.
// Ports: a/b/c inputs, lo/md/hi sorted outputs, all DATA_W bits.
module sort3_net #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] md,
  output logic [DATA_W-1:0] hi
);

  logic [DATA_W-1:0] l1;
  logic [DATA_W-1:0] h1;
  logic [DATA_W-1:0] t;

  // Order a/b first; c then meets the smaller of the pair to find the global
  // minimum, and the loser of that contest is ranked against the larger one.
  always_comb begin
    l1 = (a < b) ? a : b;
    h1 = (a < b) ? b : a;
    lo = (l1 < c) ? l1 : c;
    t  = (l1 < c) ? c : l1;
    md = (t < h1) ? t : h1;
    hi = (t < h1) ? h1 : t;
  end

endmodule

// File: rtl/window3x3_rank_filter.sv
// Purpose: 3x3 rank filter (min/median/max) over the last three accepted window columns.
// Latency: 3 register stages; result visible 3 cycles after the completing column is presented.
// Backpressure: global stall; in_ready = !out_valid || out_ready, outputs held while stalled.
// Ports: clk/rst (sync, active low); in_valid/in_ready/in_sol/in_mode/col_top/col_mid/col_bot
//        input column handshake; out_valid/out_ready/out_data result handshake.
module window3x3_rank_filter
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sol,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] col_top,
  input  logic [DATA_W-1:0] col_mid,
  input  logic [DATA_W-1:0] col_bot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // ---------------- stage 1: column sort + window shift ----------------
  logic [DATA_W-1:0] c_lo, c_md, c_hi;
  logic [DATA_W-1:0] w_lo [3];
  logic [DATA_W-1:0] w_md [3];
  logic [DATA_W-1:0] w_hi [3];
  logic [1:0]        fill;
  logic [1:0]        fill_next;
  logic              v1;
  mode_e             mode1;

  sort3_net #(.DATA_W(DATA_W)) u_col_sort (
    .a(col_top), .b(col_mid), .c(col_bot),
    .lo(c_lo), .md(c_md), .hi(c_hi)
  );

  // fill counts valid columns in the current line; reset leaves it at 0 so the
  // first column afterwards starts a new line without needing in_sol.
  always_comb begin
    fill_next = fill;
    if (in_sol)           fill_next = 2'd1;
    else if (fill != 2'd3) fill_next = fill + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        w_lo[i] <= '0;
        w_md[i] <= '0;
        w_hi[i] <= '0;
      end
      fill  <= 2'd0;
      v1    <= 1'b0;
      mode1 <= MODE_MIN;
    end else if (en) begin
      v1 <= accept && (fill_next == 2'd3);
      if (accept) begin
        fill    <= fill_next;
        mode1   <= mode_e'(in_mode);
        w_lo[0] <= c_lo;
        w_md[0] <= c_md;
        w_hi[0] <= c_hi;
        for (int i = 1; i < 3; i++) begin
          w_lo[i] <= w_lo[i-1];
          w_md[i] <= w_md[i-1];
          w_hi[i] <= w_hi[i-1];
        end
      end
    end
  end

  // ---------------- stage 2: cross-column reductions ----------------
  // With every column sorted, the 9-pixel median equals the median of
  // (largest low, median of mids, smallest high).
  logic [DATA_W-1:0] md_med;
  logic [DATA_W-1:0] unused_md_lo, unused_md_hi;
  logic [DATA_W-1:0] lo_max_q, md_med_q, hi_min_q, gmin_q, gmax_q;
  logic              v2;
  mode_e             mode2;

  sort3_net #(.DATA_W(DATA_W)) u_md_sort (
    .a(w_md[0]), .b(w_md[1]), .c(w_md[2]),
    .lo(unused_md_lo), .md(md_med), .hi(unused_md_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      lo_max_q <= '0;
      md_med_q <= '0;
      hi_min_q <= '0;
      gmin_q   <= '0;
      gmax_q   <= '0;
      v2       <= 1'b0;
      mode2    <= MODE_MIN;
    end else if (en) begin
      lo_max_q <= max2(max2(w_lo[0], w_lo[1]), w_lo[2]);
      md_med_q <= md_med;
      hi_min_q <= min2(min2(w_hi[0], w_hi[1]), w_hi[2]);
      gmin_q   <= min2(min2(w_lo[0], w_lo[1]), w_lo[2]);
      gmax_q   <= max2(max2(w_hi[0], w_hi[1]), w_hi[2]);
      v2       <= v1;
      mode2    <= mode1;
    end
  end

  // ---------------- stage 3: rank select ----------------
  logic [DATA_W-1:0] fin_med;
  logic [DATA_W-1:0] unused_fin_lo, unused_fin_hi;

  sort3_net #(.DATA_W(DATA_W)) u_fin_sort (
    .a(lo_max_q), .b(md_med_q), .c(hi_min_q),
    .lo(unused_fin_lo), .md(fin_med), .hi(unused_fin_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= v2;
      case (mode2)
        MODE_MIN: out_data <= gmin_q;
        MODE_MAX: out_data <= gmax_q;
        default:  out_data <= fin_med;
      endcase
    end
  end

endmodule

// File: tb/tb_window3x3_rank_filter.sv
// Bench for window3x3_rank_filter: directed scenarios plus randomized traffic, checked
// against a 9-pixel sort-and-pick model. Two instances (8-bit and 12-bit) run in lockstep.
module tb_window3x3_rank_filter;
  import rank_filter_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_sol, out_ready;
  logic [1:0]  in_mode;
  logic [11:0] t12, m12, b12;
  logic        in_ready, out_valid, in_ready12, out_valid12;
  logic [7:0]  out_data;
  logic [11:0] out_data12;

  window3x3_rank_filter #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol),
    .in_mode(in_mode), .col_top(t12[7:0]), .col_mid(m12[7:0]), .col_bot(b12[7:0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  window3x3_rank_filter #(.DATA_W(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12), .in_sol(in_sol),
    .in_mode(in_mode), .col_top(t12), .col_mid(m12), .col_bot(b12),
    .out_valid(out_valid12), .out_ready(out_ready), .out_data(out_data12)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_fill = 0;
  int win8[$];
  int win12[$];
  int exp8[$];
  int exp12[$];
  int n_out = 0;
  int last8 = 0;
  int last12 = 0;

  function automatic int rank9(input int w[$], input logic [1:0] mode);
    int s[$];
    s = w;
    s.sort();
    if (mode == 2'd0) return s[0];
    if (mode == 2'd2) return s[8];
    return s[4];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      m_fill = 0;
      win8.delete();
      win12.delete();
      exp8.delete();
      exp12.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("lockstep_vld", out_valid12, 1);
        if (exp8.size() == 0) chk("unexpected_out", 0, 1);
        else begin
          chk("out8", out_data, exp8.pop_front());
          chk("out12", out_data12, exp12.pop_front());
        end
        last8 = out_data;
        last12 = out_data12;
        n_out++;
      end
      if (in_valid && in_ready) begin
        if (in_sol) begin
          m_fill = 1;
          win8.delete();
          win12.delete();
        end else if (m_fill < 3) m_fill++;
        win8.push_back(int'(t12[7:0]));
        win8.push_back(int'(m12[7:0]));
        win8.push_back(int'(b12[7:0]));
        win12.push_back(int'(t12));
        win12.push_back(int'(m12));
        win12.push_back(int'(b12));
        while (win8.size() > 9) void'(win8.pop_front());
        while (win12.size() > 9) void'(win12.pop_front());
        if (m_fill == 3) begin
          exp8.push_back(rank9(win8, in_mode));
          exp12.push_back(rank9(win12, in_mode));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_col(input logic [11:0] t, input logic [11:0] m, input logic [11:0] b,
                          input logic sol, input logic [1:0] mode);
    bit ok;
    ok = 0;
    t12 = t; m12 = m; b12 = b; in_sol = sol; in_mode = mode; in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    in_sol = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (exp8.size() == 0) break;
      tick();
    end
    chk("drain", exp8.size(), 0);
  endtask

  task automatic wait_out_valid(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      tick();
    end
    chk(tag, out_valid, 1);
  endtask

  function automatic logic [11:0] rv();
    if ($urandom_range(0, 1) == 1) return 12'($urandom_range(0, 4095));
    return 12'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_mode = 2'd0; out_ready = 1'b1;
    t12 = '0; m12 = '0; b12 = '0;
    repeat (3) tick();
    chk("rst_vld", out_valid, 0);
    chk("rst_dat", out_data, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld12", out_valid12, 0);
    rst = 1'b1;
    tick();

    // 1: median of the reference window, with latency
    n0 = n_out;
    send_col(12'd10, 12'd50, 12'd90, 1'b1, 2'd1);
    send_col(12'd20, 12'd60, 12'd80, 1'b0, 2'd1);
    send_col(12'd30, 12'd70, 12'd40, 1'b0, 2'd1);
    chk("t1_lat1", out_valid, 0);
    tick();
    chk("t1_lat2", out_valid, 0);
    tick();
    chk("t1_lat3", out_valid, 1);
    chk("t1_dat", out_data, 50);
    wait_drain();
    chk("t1_cnt", n_out - n0, 1);

    // 2: min / max of the same window, then a fourth column
    send_col(12'd10, 12'd50, 12'd90, 1'b1, 2'd0);
    send_col(12'd20, 12'd60, 12'd80, 1'b0, 2'd0);
    send_col(12'd30, 12'd70, 12'd40, 1'b0, 2'd0);
    wait_drain();
    chk("t2_min", last8, 10);
    send_col(12'd10, 12'd50, 12'd90, 1'b1, 2'd2);
    send_col(12'd20, 12'd60, 12'd80, 1'b0, 2'd2);
    send_col(12'd30, 12'd70, 12'd40, 1'b0, 2'd2);
    wait_drain();
    chk("t2_max", last8, 90);
    send_col(12'd99, 12'd99, 12'd99, 1'b0, 2'd1);
    wait_drain();
    chk("t2_4th_med", last8, 70);

    // 3: downstream stall holds output and blocks input
    n0 = n_out;
    out_ready = 1'b0;
    send_col(12'd1, 12'd2, 12'd3, 1'b1, 2'd1);
    send_col(12'd4, 12'd5, 12'd6, 1'b0, 2'd1);
    send_col(12'd7, 12'd8, 12'd9, 1'b0, 2'd1);
    wait_out_valid("t3_vld");
    t12 = 12'd100; m12 = 12'd101; b12 = 12'd102; in_mode = 2'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_vld", out_valid, 1);
      chk("t3_hold_dat", out_data, 5);
      chk("t3_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    send_col(12'd100, 12'd101, 12'd102, 1'b0, 2'd1);
    send_col(12'd200, 12'd201, 12'd202, 1'b0, 2'd0);
    wait_drain();
    chk("t3_cnt", n_out - n0, 3);
    chk("t3_last", last8, 7);

    // 4: start of line mid-window restarts the fill
    n0 = n_out;
    send_col(12'd1, 12'd1, 12'd1, 1'b1, 2'd1);
    send_col(12'd2, 12'd2, 12'd2, 1'b0, 2'd1);
    send_col(12'd3, 12'd3, 12'd3, 1'b1, 2'd1);
    send_col(12'd4, 12'd4, 12'd4, 1'b0, 2'd1);
    repeat (5) tick();
    chk("t4_none", n_out - n0, 0);
    send_col(12'd5, 12'd5, 12'd5, 1'b0, 2'd1);
    wait_drain();
    chk("t4_one", n_out - n0, 1);
    chk("t4_med", last8, 4);

    // 5: all-equal windows at full scale and with ties, all modes
    for (int md = 0; md < 3; md++) begin
      send_col(12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 2'(md));
      send_col(12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 2'(md));
      send_col(12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 2'(md));
      wait_drain();
      chk("t5_ff8", last8, 8'hFF);
      chk("t5_fff12", last12, 12'hFFF);
    end
    send_col(12'd5, 12'd5, 12'd5, 1'b1, 2'd0);
    send_col(12'd5, 12'd5, 12'd5, 1'b0, 2'd0);
    for (int md = 0; md < 4; md++) begin
      send_col(12'd5, 12'd5, 12'd5, 1'b0, 2'(md));
      wait_drain();
      chk("t5_tie", last8, 5);
    end

    // 6: reset mid-stream with a held result
    out_ready = 1'b0;
    send_col(12'd9, 12'd8, 12'd7, 1'b1, 2'd1);
    send_col(12'd6, 12'd5, 12'd4, 1'b0, 2'd1);
    send_col(12'd3, 12'd2, 12'd1, 1'b0, 2'd1);
    wait_out_valid("t6_vld_pre");
    rst = 1'b0;
    tick();
    chk("t6_rst_vld", out_valid, 0);
    chk("t6_rst_dat", out_data, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    send_col(12'd11, 12'd12, 12'd13, 1'b0, 2'd1);
    send_col(12'd14, 12'd15, 12'd16, 1'b0, 2'd1);
    repeat (5) tick();
    chk("t6_none", n_out - n0, 0);
    send_col(12'd17, 12'd18, 12'd19, 1'b0, 2'd1);
    wait_drain();
    chk("t6_one", n_out - n0, 1);
    chk("t6_med", last8, 15);

    // randomized traffic with bubbles, stalls, sol and mode changes
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sol    = ($urandom_range(0, 9) == 0);
      in_mode   = 2'($urandom_range(0, 3));
      t12 = rv(); m12 = rv(); b12 = rv();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    in_sol = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("rand_seen", (n_out > 100) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
